conv_encoder_framed: RTL and testbench
======================================

# conv_encoder_framed

Rate-1/2 feedforward convolutional encoder that produces the 2-bit code symbols the Viterbi decoder consumes. It accepts one information bit per handshake and emits one code symbol per bit. After every FRAME_LEN bits it appends K-1 zero tail bits, which returns the trellis to state 0 as the decoder expects. It is the transmit-side counterpart of the branch-metric/ACS/traceback chain and drives decoder test streams and loopback.

## Interface
- K, 3: constraint length; must be at least 2; encoder memory is K-1 bits.
- G0, 3'b111: generator polynomial for o_code[1]; K bits wide; MSB taps the current bit.
- G1, 3'b101: generator polynomial for o_code[0]; K bits wide.
- FRAME_LEN, 8: information bits per frame; must be at least 1.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset; asynchronous, active-low.
- i_data  input  1  information bit.
- i_valid  input  1  i_data is valid.
- o_ready  output  1  encoder accepts i_data this cycle.
- o_code  output  2  code symbol {c0, c1}; encoding matches the decoder expected codes 2'b00..2'b11.
- o_valid  output  1  o_code is valid.
- i_ready  input  1  downstream accepts o_code.
- o_first  output  1  o_code is the first symbol of a frame.
- o_last  output  1  o_code is the last tail symbol of a frame.

## Operation
- Window w = {u_t, u_t-1, ..., u_t-K+1}, MSB = current input; the shift register sr holds the K-1 previous bits.
- Code bits: c0 = XOR-reduce(w & G0); c1 = XOR-reduce(w & G1); o_code = {c0, c1}.
- Output slot is free when !o_valid || i_ready.
- o_ready = (state != TAIL) && slot free. It is combinational from registered state and i_ready.
- A symbol is produced when the input is accepted (i_valid && o_ready), or in TAIL with a free slot using u = 0. On production: o_code, o_first and o_last are registered, o_valid is set, and sr shifts in u.
- Slot free and nothing produced: o_valid is cleared.
- Counters:
  - bit_cnt, width $clog2(FRAME_LEN+1), counts accepted bits.
  - tail_cnt, width $clog2(K), counts emitted tail symbols.
- FSM:
  - IDLE: bit_cnt = 0, sr = 0. An accept sets o_first and goes to DATA, or to TAIL if FRAME_LEN == 1.
  - DATA: each accept increments bit_cnt. The accept that makes FRAME_LEN bits goes to TAIL.
  - TAIL: o_ready = 0. Emits K-1 zero-input symbols, one per free slot. The (K-1)th symbol has o_last = 1; it clears bit_cnt and tail_cnt and goes to IDLE. sr is all-zero at that point.
- o_first and o_last are each high only with their own symbol. They never coincide, since K-1 is at least 1.

## Timing
- Reset values: state IDLE, sr = 0, bit_cnt = 0, tail_cnt = 0, o_valid = 0, o_code = 2'b00, o_first = 0, o_last = 0. With reset deasserted this gives o_ready = 1.
- Latency: a bit accepted at edge N makes its symbol valid immediately after edge N, i.e. 1 cycle.
- Throughput: 1 symbol per cycle while i_ready = 1.
- Each frame costs FRAME_LEN + K - 1 output cycles. During tail emission o_ready is low for K-1 cycles, assuming i_ready is held high.
- Backpressure: while o_valid && !i_ready, o_code, o_first and o_last hold, o_ready = 0, and no state changes.
- Simultaneous events: downstream consumes and upstream supplies in the same cycle, giving back-to-back symbols with no bubble.
- Frame boundary: the first bit of the next frame is accepted the cycle after the o_last symbol is produced, if the slot is free.
- Reset mid-frame: immediately returns every output to its reset value and discards the partial frame. The next accepted bit starts a new frame with o_first = 1.

## Structure
- The shared package viterbi_pkg holds:
  - localparams K, G0, G1 and the code width 2 (shared with the decoder);
  - enc_state_t enum {IDLE, DATA, TAIL}.
- One natural sub-module, conv_codeword_gen: combinational, takes a K-bit window and returns the 2-bit symbol. The team's decoder model reuses it.
- Remaining RTL lives in this block: FSM, counters, shift register and output register.

## Test plan
- Basic frame, FRAME_LEN=4, K=3, G=7,5, i_ready=1: input 1,0,1,1 -> o_code 11,10,00,01 then tail 01,11. o_first is high on the first symbol and o_last on the sixth; o_ready is low for 2 cycles.
- Backpressure: the same frame with i_ready low for 3 cycles after the second symbol -> o_code holds 10 for those cycles, o_ready = 0, final sequence unchanged.
- Back-to-back frames, i_valid held high: two frames 1011 and 0000 -> 11,10,00,01,01,11 then 00,00,00,00,00,00. No bubble beyond the 2 tail cycles; sr is 0 at each frame start.
- All-zero and all-one: all-zero input -> all 00. FRAME_LEN=4 with input 1111 -> 11,01,10,10,01,11.
- Reset mid-frame: assert i_rst_n low after 2 accepted bits -> outputs drop to reset values asynchronously. After release, 1011 reproduces the basic-frame sequence with o_first set.
- FRAME_LEN=1: input 1 -> 11 (o_first), then tail 10, 11 (o_last). The FSM returns to IDLE.

Source files
------------

// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - code parameters and encoder state shared by encoder and decoder
package viterbi_pkg;

    localparam int K = 3;
    localparam logic [K-1:0] G0 = 3'b111;
    localparam logic [K-1:0] G1 = 3'b101;
    localparam int CODE_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } enc_state_t;

endpackage

// File: rtl/conv_codeword_gen.sv
// rtl/conv_codeword_gen.sv - combinational rate-1/2 code symbol from a K-bit window
module conv_codeword_gen #(
    parameter int K = viterbi_pkg::K,
    parameter logic [K-1:0] G0 = viterbi_pkg::G0,
    parameter logic [K-1:0] G1 = viterbi_pkg::G1
) (
    input  logic [K-1:0] window,
    output logic [1:0]   code
);

    // window MSB is the current bit; code = {c0, c1}
    assign code = {^(window & G0), ^(window & G1)};

endmodule

// File: rtl/conv_encoder_framed.sv
// rtl/conv_encoder_framed.sv - framed convolutional encoder with zero-tail termination
module conv_encoder_framed #(
    parameter int K = viterbi_pkg::K,
    parameter logic [K-1:0] G0 = viterbi_pkg::G0,
    parameter logic [K-1:0] G1 = viterbi_pkg::G1,
    parameter int FRAME_LEN = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_data,
    input  logic                            i_valid,
    output logic                            o_ready,
    output logic [viterbi_pkg::CODE_W-1:0]  o_code,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic                            o_first,
    output logic                            o_last
);

    import viterbi_pkg::*;

    localparam int BW = $clog2(FRAME_LEN + 1);
    localparam int TW = $clog2(K);

    enc_state_t state, state_d;
    logic [K-2:0]  sr;
    logic [BW-1:0] bit_cnt, bit_cnt_d;
    logic [TW-1:0] tail_cnt, tail_cnt_d;
    logic          first_d, last_d;

    logic          slot_free, accept, tail_emit, produce, u;
    logic [K-1:0]  window;
    logic [CODE_W-1:0] code;

    assign slot_free = !o_valid || i_ready;
    assign o_ready   = (state != TAIL) && slot_free;
    assign accept    = i_valid && o_ready;
    assign tail_emit = (state == TAIL) && slot_free;
    assign produce   = accept || tail_emit;
    assign u         = tail_emit ? 1'b0 : i_data;
    assign window    = {u, sr};

    conv_codeword_gen #(
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) u_codeword_gen (
        .window (window),
        .code   (code)
    );

    always_comb begin
        state_d    = state;
        bit_cnt_d  = bit_cnt;
        tail_cnt_d = tail_cnt;
        first_d    = 1'b0;
        last_d     = 1'b0;
        case (state)
            IDLE, DATA: begin
                if (accept) begin
                    first_d   = (state == IDLE);
                    bit_cnt_d = bit_cnt + BW'(1);
                    state_d   = (bit_cnt == BW'(FRAME_LEN - 1)) ? TAIL : DATA;
                end
            end
            TAIL: begin
                if (tail_emit) begin
                    if (tail_cnt == TW'(K - 2)) begin
                        last_d     = 1'b1;
                        bit_cnt_d  = '0;
                        tail_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        tail_cnt_d = tail_cnt + TW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            tail_cnt <= '0;
        end else begin
            state    <= state_d;
            bit_cnt  <= bit_cnt_d;
            tail_cnt <= tail_cnt_d;
        end
    end

    // new sr is the window minus its oldest bit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sr      <= '0;
            o_code  <= '0;
            o_valid <= 1'b0;
            o_first <= 1'b0;
            o_last  <= 1'b0;
        end else if (produce) begin
            sr      <= window[K-1:1];
            o_code  <= code;
            o_valid <= 1'b1;
            o_first <= first_d;
            o_last  <= last_d;
        end else if (slot_free) begin
            o_valid <= 1'b0;
            o_first <= 1'b0;
            o_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_encoder_framed.sv
// tb/tb_conv_encoder_framed.sv - directed self-checking bench for conv_encoder_framed
module tb_conv_encoder_framed;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       d4, v4, rdy4, vo4, ird4, f4, l4;
    logic [1:0] c4;
    logic       d1, v1, rdy1, vo1, ird1, f1, l1;
    logic [1:0] c1;

    conv_encoder_framed #(.K(3), .G0(3'b111), .G1(3'b101), .FRAME_LEN(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(d4), .i_valid(v4), .o_ready(rdy4),
        .o_code(c4), .o_valid(vo4), .i_ready(ird4), .o_first(f4), .o_last(l4)
    );

    conv_encoder_framed #(.K(3), .G0(3'b111), .G1(3'b101), .FRAME_LEN(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(d1), .i_valid(v1), .o_ready(rdy1),
        .o_code(c1), .o_valid(vo1), .i_ready(ird1), .o_first(f1), .o_last(l1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // symbols captured as {first, last, code} when consumed downstream
    logic [3:0] q4[$];
    logic [3:0] q1[$];

    always @(negedge clk) begin
        if (rst_n && vo4 && ird4) q4.push_back({f4, l4, c4});
        if (rst_n && vo1 && ird1) q1.push_back({f1, l1, c1});
    end

    task automatic wait_ready4();
        int n = 0;
        @(negedge clk);
        while (!rdy4 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!rdy4) check("ready_timeout", {31'd0, rdy4}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic feed4(input logic [3:0] bits, input int nbits, input bit hold);
        for (int i = 0; i < nbits; i++) begin
            d4 = bits[3-i];
            v4 = 1'b1;
            wait_ready4();
        end
        if (!hold) v4 = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [3:0] e [6]);
        logic [3:0] got;
        for (int i = 0; i < 6; i++) begin
            got = (q4.size() > 0) ? q4.pop_front() : 4'hF;
            check($sformatf("%s[%0d]", tag, i), {28'd0, got}, {28'd0, e[i]});
        end
    endtask

    task automatic drain();
        repeat (8) @(posedge clk);
        #1;
    endtask

    logic [3:0] fr_basic [6] = '{4'b1011, 4'b0010, 4'b0000, 4'b0001, 4'b0001, 4'b0111};
    logic [3:0] fr_zero  [6] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
    logic [3:0] fr_ones  [6] = '{4'b1011, 4'b0001, 4'b0010, 4'b0010, 4'b0001, 4'b0111};

    initial begin
        int n;
        rst_n = 1'b0;
        d4 = 0; v4 = 0; ird4 = 1;
        d1 = 0; v1 = 0; ird1 = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, vo4}, 32'd0);
        check("rst_code",  {30'd0, c4},  32'd0);
        check("rst_first", {31'd0, f4},  32'd0);
        check("rst_last",  {31'd0, l4},  32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_ready", {31'd0, rdy4}, 32'd1);

        // basic frame and tail ready-low window
        feed4(4'b1011, 4, 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rdy4) break;
            n++;
        end
        check("tail_ready_low", n, 32'd2);
        drain();
        check("basic_cnt", q4.size(), 32'd6);
        check_frame("basic", fr_basic);

        // backpressure after the second symbol
        feed4(4'b1000, 2, 1);
        d4 = 1'b1;
        ird4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_code",  {30'd0, c4},   32'd2);
            check("bp_valid", {31'd0, vo4},  32'd1);
            check("bp_ready", {31'd0, rdy4}, 32'd0);
        end
        @(posedge clk);
        #1;
        ird4 = 1'b1;
        feed4(4'b1100, 2, 0);
        drain();
        check("bp_cnt", q4.size(), 32'd6);
        check_frame("bp", fr_basic);

        // back-to-back frames with i_valid held high
        fork
            begin
                feed4(4'b1011, 4, 1);
                feed4(4'b0000, 4, 0);
            end
            begin
                int k = 0;
                int run = 0;
                @(negedge clk);
                while (!vo4 && k < 20) begin
                    k++;
                    @(negedge clk);
                end
                for (int i = 0; i < 12; i++) begin
                    if (vo4) run++;
                    @(negedge clk);
                end
                check("b2b_valid_run", run, 32'd12);
            end
        join
        drain();
        check("b2b_cnt", q4.size(), 32'd12);
        check_frame("b2b_f0", fr_basic);
        check_frame("b2b_f1", fr_zero);

        // all-ones frame
        feed4(4'b1111, 4, 0);
        drain();
        check("ones_cnt", q4.size(), 32'd6);
        check_frame("ones", fr_ones);

        // asynchronous reset mid-frame
        feed4(4'b1000, 2, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, vo4}, 32'd0);
        check("mid_rst_code",  {30'd0, c4},  32'd0);
        check("mid_rst_first", {31'd0, f4},  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q4.delete();
        feed4(4'b1011, 4, 0);
        drain();
        check("post_rst_cnt", q4.size(), 32'd6);
        check_frame("post_rst", fr_basic);

        // FRAME_LEN = 1
        d1 = 1'b1;
        v1 = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rdy1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        v1 = 1'b0;
        drain();
        check("f1_cnt", q1.size(), 32'd3);
        check("f1_s0", (q1.size() > 0) ? {28'd0, q1[0]} : 32'hFF, 32'b1011);
        check("f1_s1", (q1.size() > 1) ? {28'd0, q1[1]} : 32'hFF, 32'b0010);
        check("f1_s2", (q1.size() > 2) ? {28'd0, q1[2]} : 32'hFF, 32'b0111);
        check("f1_idle_ready", {31'd0, rdy1}, 32'd1);
        check("f1_idle_valid", {31'd0, vo1},  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
